apb_fsm_controller: RTL and testbench
=====================================

// Module: apb_fsm_controller
// PURPOSE
//  Sequences APB transfers for the AHB-to-APB bridge. Takes transfers qualified by the AHB
//  slave interface (valid, haddr, hwrite, tempselx, hwdata) and drives the APB SETUP/ENABLE
//  phases. Stalls AHB through hreadyout, supports APB wait states (pready), and turns a
//  pslverr or a wait-state timeout into a two-cycle AHB ERROR response.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  NSEL      3  number of APB slave selects (one-hot, matches tempselx)
//  TIMEOUT  16  ENABLE cycles with pready=0 before abort; 0 disables timeout
//  CNT_W     5  wait counter width; must hold TIMEOUT
// PORTS
//  hclk       in   1       bridge clock, all logic on rising edge
//  hreset     in   1       synchronous active-high reset
//  valid      in   1       AHB transfer qualified (hreadyin, NONSEQ/SEQ, address in range)
//  hwrite     in   1       AHB direction of the transfer flagged by valid
//  haddr      in   ADDR_W  AHB address-phase address
//  hwdata     in   DATA_W  AHB write data (data phase)
//  tempselx   in   NSEL    one-hot decoded slave select for haddr
//  pready     in   1       APB slave ready
//  pslverr    in   1       APB slave error, sampled only with pready=1 in ENABLE
//  paddr      out  ADDR_W  APB address (registered)
//  pwdata     out  DATA_W  APB write data (registered)
//  pselx      out  NSEL    APB selects (registered)
//  penable    out  1       APB enable (registered)
//  pwrite     out  1       APB direction (registered)
//  hreadyout  out  1       AHB ready to master (combinational from state/pready)
//  hresp      out  2       AHB response: 00 OKAY, 01 ERROR (combinational from state)
// BEHAVIOUR
//  States: IDLE, WWAIT, SETUP, ENABLE, ERR1, ERR2. Reset -> IDLE. paddr, pwdata, pselx,
//  penable and pwrite reset to 0. Reset mid-transfer drops pselx/penable on the next edge.
//  Accept point: IDLE, ERR2, or ENABLE with pready=1. valid=1 there latches addr_q<=haddr,
//  sel_q<=tempselx, wr_q<=hwrite. Next state is WWAIT if hwrite=1, SETUP if hwrite=0.
//  No accept at a point -> IDLE. valid is ignored in all other states.
//  IDLE:   hreadyout=1, hresp=00.
//  WWAIT:  hreadyout=0, wdata_q<=hwdata; -> SETUP.
//  SETUP:  pselx=sel_q, paddr=addr_q, pwrite=wr_q, pwdata=wdata_q (held from last write on
//          reads), penable=0, hreadyout=0, wait counter cleared; -> ENABLE.
//  ENABLE: penable=1; pselx/paddr/pwrite/pwdata held.
//          pready=0: hreadyout=0, counter++. If TIMEOUT!=0 and counter==TIMEOUT-1 -> ERR1.
//          pready=1, pslverr=0: hreadyout=1, hresp=00, transfer done; take accept point.
//          pready=1, pslverr=1: hreadyout=0, -> ERR1.
//          pready=1 in the timeout cycle counts as completion (completion wins).
//  ERR1:   pselx=0, penable=0, hreadyout=0, hresp=01; -> ERR2.
//  ERR2:   hreadyout=1, hresp=01; take accept point.
//  Every APB transfer is exactly 1 SETUP + >=1 ENABLE cycle. No back-to-back ENABLE
//  without SETUP. pselx=0 and penable=0 outside SETUP/ENABLE.
//  Latency, completion edge to next APB SETUP: read 1 cycle; write 2 cycles (via WWAIT).
// TESTING
//  Read, pready=1: valid,hwrite=0,haddr=8000_0010,sel=001 -> SETUP next cycle with
//    pselx=001, paddr=8000_0010, pwrite=0; ENABLE cycle penable=1, hreadyout=1; -> IDLE.
//  Write: valid,hwrite=1,haddr=8400_0004; next cycle hwdata=DEADBEEF -> WWAIT, then SETUP
//    with pselx=010, pwrite=1, pwdata=DEADBEEF, then ENABLE; hreadyout=0 until ENABLE.
//  Wait states: pready low 3 ENABLE cycles -> penable/pselx held, hreadyout=0 for those
//    3 cycles, hreadyout=1 on the 4th; counter restarts at next SETUP.
//  Back-to-back: read then write accepted in the completing ENABLE cycle ->
//    ENABLE->WWAIT->SETUP; read then read -> ENABLE->SETUP directly.
//  Timeout, TIMEOUT=16, pready stuck 0: 16 ENABLE cycles, then ERR1 (hresp=01,
//    hreadyout=0, pselx=0), then ERR2 (hresp=01, hreadyout=1), then IDLE.
//  pslverr=1 with pready=1 -> ERR1, ERR2 as above. hreset=1 during ENABLE -> next cycle
//    IDLE, all APB outputs 0, hreadyout=1, hresp=00.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// APB transfer sequencer for the AHB-to-APB bridge: SETUP/ENABLE phasing, AHB stall,
// wait-state timeout and two-cycle AHB ERROR response.
module apb_fsm_controller #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSEL    = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   tempselx,
  input  logic              pready,
  input  logic              pslverr,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic              hreadyout,
  output logic [1:0]        hresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_SETUP, S_ENABLE, S_ERR1, S_ERR2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic [NSEL-1:0]   r_sel_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [NSEL-1:0]   r_pselx;
  logic              r_penable;
  logic              r_pwrite;

  logic       w_done;
  logic       w_accept_pt;
  logic       w_timeout;
  logic       w_hreadyout;
  logic [1:0] w_hresp;

  assign w_done      = (r_state == S_ENABLE) && pready && !pslverr;
  assign w_accept_pt = (r_state == S_IDLE) || (r_state == S_ERR2) || w_done;
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_sel_q   <= '0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pselx   <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
    end else begin
      case (r_state)
        S_WWAIT: begin
          // pwdata doubles as the write-data holding register, so reads keep the last write
          r_pwdata <= hwdata;
          r_paddr  <= r_addr_q;
          r_pselx  <= r_sel_q;
          r_pwrite <= 1'b1;
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ENABLE;
        end
        S_ENABLE: begin
          if (!pready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout) begin
              r_pselx   <= '0;
              r_penable <= 1'b0;
              r_state   <= S_ERR1;
            end
          end else if (pslverr) begin
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_state   <= S_ERR1;
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        default: r_state <= S_IDLE;
      endcase

      // Accept point overrides the per-state defaults above.
      if (w_accept_pt) begin
        r_pselx   <= '0;
        r_penable <= 1'b0;
        r_state   <= S_IDLE;
        if (valid) begin
          r_addr_q <= haddr;
          r_sel_q  <= tempselx;
          if (hwrite) begin
            r_state <= S_WWAIT;
          end else begin
            r_paddr  <= haddr;
            r_pselx  <= tempselx;
            r_pwrite <= 1'b0;
            r_state  <= S_SETUP;
          end
        end
      end
    end
  end

  always_comb begin
    w_hreadyout = 1'b0;
    w_hresp     = 2'b00;
    case (r_state)
      S_IDLE:   w_hreadyout = 1'b1;
      S_ENABLE: w_hreadyout = pready & ~pslverr;
      S_ERR1:   w_hresp     = 2'b01;
      S_ERR2: begin
        w_hreadyout = 1'b1;
        w_hresp     = 2'b01;
      end
      default: w_hreadyout = 1'b0;
    endcase
  end

  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign hreadyout = w_hreadyout;
  assign hresp     = w_hresp;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboarded random bench for apb_fsm_controller: a driver/APB-slave process pushes expected
// transfers, an independent monitor pops and checks each APB transfer and its AHB response.
module tb_apb_fsm_controller;

  localparam int TIMEOUT = 16;
  localparam int NTX     = 200;
  localparam int NDIR    = 8;

  logic        hclk = 1'b0;
  logic        hreset, valid, hwrite, pready, pslverr;
  logic [31:0] haddr, hwdata;
  logic [2:0]  tempselx;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pselx;
  logic        penable, pwrite, hreadyout;
  logic [1:0]  hresp;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .tempselx(tempselx), .pready(pready), .pslverr(pslverr),
    .paddr(paddr), .pwdata(pwdata), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .hreadyout(hreadyout), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  sel;
    logic        wr;
    logic [31:0] wd;
    int          n_en;
    logic        err;
    int          setup_cyc;
  } exp_t;

  typedef struct {
    int   nwait;
    logic err;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, issued = 0;
  logic mon_on = 1'b0;

  always @(posedge hclk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Directed opening transfers, then random ones.
  logic [31:0] d_addr [NDIR] = '{32'h8000_0010, 32'h8400_0004, 32'h8000_0020, 32'h8000_0030,
                                 32'h8000_0040, 32'h8400_0050, 32'h8000_0060, 32'h8000_0070};
  logic [2:0]  d_sel  [NDIR] = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001};
  logic        d_wr   [NDIR] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] d_wd   [NDIR] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h1357_9BDF, 32'h0, 32'h0};
  int          d_nw   [NDIR] = '{0, 0, 3, 16, 15, 0, 0, 0};
  logic        d_err  [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Driver (AHB side) and APB slave responder.
  initial begin : stim
    slv_t        cur;
    exp_t        e;
    int          ecnt, nw, r;
    logic        pend_wr, ferr;
    logic [31:0] pend_wd, last_wd;
    cur = '{nwait: 0, err: 1'b0};
    ecnt = 0; pend_wr = 1'b0; pend_wd = '0; last_wd = '0;
    wait (mon_on);
    forever begin
      @(negedge hclk);
      if (penable) begin
        pready  = (ecnt == cur.nwait);
        pslverr = pready & cur.err;
        ecnt++;
      end else begin
        if (pselx != 3'b000) begin
          if (slv_q.size() != 0) cur = slv_q.pop_front();
          else cur = '{nwait: 0, err: 1'b0};
          ecnt = 0;
        end
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
      end
      #1;
      if (pend_wr) begin
        hwdata  = pend_wd;
        pend_wr = 1'b0;
      end else begin
        hwdata = $urandom;
      end
      if (hreadyout && issued < NTX && (issued < NDIR || $urandom_range(0, 3) != 0)) begin
        if (issued < NDIR) begin
          e.addr = d_addr[issued]; e.sel = d_sel[issued]; e.wr = d_wr[issued];
          e.wd = d_wd[issued]; nw = d_nw[issued]; ferr = d_err[issued];
        end else begin
          e.addr = $urandom;
          e.sel  = 3'b001 << $urandom_range(0, 2);
          e.wr   = 1'($urandom);
          e.wd   = $urandom;
          r = $urandom_range(0, 9);
          if (r < 5) nw = 0;
          else if (r < 8) nw = $urandom_range(1, 3);
          else if (r == 8) nw = $urandom_range(TIMEOUT - 1, TIMEOUT);
          else nw = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
          ferr = ($urandom_range(0, 7) == 0);
        end
        // Reference: reads present the most recent write data; a stuck slave aborts after TIMEOUT.
        if (e.wr) last_wd = e.wd;
        valid    = 1'b1;
        hwrite   = e.wr;
        haddr    = e.addr;
        tempselx = e.sel;
        if (e.wr) begin pend_wr = 1'b1; pend_wd = e.wd; end
        e.wd        = last_wd;
        e.n_en      = (nw >= TIMEOUT) ? TIMEOUT : nw + 1;
        e.err       = ferr || (nw >= TIMEOUT);
        e.setup_cyc = cyc + (e.wr ? 2 : 1);
        exp_q.push_back(e);
        slv_q.push_back('{nwait: nw, err: ferr});
        issued++;
      end else if (hreadyout) begin
        valid = 1'b0;
      end else begin
        valid    = 1'($urandom);
        hwrite   = 1'($urandom);
        haddr    = $urandom;
        tempselx = 3'($urandom);
      end
    end
  end

  // Monitor: pops one expected transfer per observed SETUP.
  initial begin : mon
    exp_t e;
    int   n, nrdy;
    logic have;
    have = 1'b0;
    wait (mon_on);
    forever begin
      if (!have) begin @(negedge hclk); #2; end
      have = 1'b0;
      if (pselx == 3'b000) begin
        chk("idle_penable", 128'(penable), 128'(0));
        chk("idle_hresp", 128'(hresp), 128'(0));
      end else begin
        chk("setup_penable", 128'(penable), 128'(0));
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_setup");
        end else begin
          e = exp_q.pop_front();
          chk("setup_paddr", 128'(paddr), 128'(e.addr));
          chk("setup_pselx", 128'(pselx), 128'(e.sel));
          chk("setup_pwrite", 128'(pwrite), 128'(e.wr));
          chk("setup_pwdata", 128'(pwdata), 128'(e.wd));
          chk("setup_latency", 128'(cyc), 128'(e.setup_cyc));
          chk("setup_hreadyout", 128'(hreadyout), 128'(0));
          n = 0; nrdy = 0;
          while (1) begin
            @(negedge hclk); #2;
            if (!penable) break;
            n++;
            chk("enable_hold", {pselx, paddr, pwrite, pwdata}, {e.sel, e.addr, e.wr, e.wd});
            chk("enable_hresp", 128'(hresp), 128'(0));
            if (hreadyout) nrdy++;
            if (n > 4 * TIMEOUT) begin flag_fail("enable_stuck"); break; end
          end
          chk("enable_cycles", 128'(n), 128'(e.n_en));
          chk("enable_ready_cycles", 128'(nrdy), 128'(e.err ? 0 : 1));
          if (e.err) begin
            chk("err1", {hresp, hreadyout, pselx, penable}, {2'b01, 1'b0, 3'b000, 1'b0});
            @(negedge hclk); #2;
            chk("err2", {hresp, hreadyout, penable}, {2'b01, 1'b1, 1'b0});
          end else begin
            have = 1'b1;
          end
        end
      end
    end
  end

  initial begin : main
    logic drained;
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    tempselx = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk); #2;
    chk("rst_pselx", 128'(pselx), 128'(0));
    chk("rst_penable", 128'(penable), 128'(0));
    chk("rst_paddr_pwdata", {paddr, pwdata}, 128'(0));
    chk("rst_pwrite", 128'(pwrite), 128'(0));
    chk("rst_ahb", {hreadyout, hresp}, {1'b1, 2'b00});

    // Reset while a read is stalled in ENABLE.
    hreset = 1'b0;
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h1234_5678; tempselx = 3'b100;
    @(negedge hclk); #1 valid = 1'b0; #1;
    chk("rstx_setup", {pselx, penable, paddr}, {3'b100, 1'b0, 32'h1234_5678});
    @(negedge hclk); #2;
    chk("rstx_enable", {penable, hreadyout}, {1'b1, 1'b0});
    hreset = 1'b1;
    @(negedge hclk); #2;
    chk("rstx_apb_zero", {pselx, penable, pwrite, paddr, pwdata}, 128'(0));
    chk("rstx_ahb", {hreadyout, hresp}, {1'b1, 2'b00});
    hreset = 1'b0;

    mon_on = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 30000 && !drained; i++) begin
      @(posedge hclk);
      drained = (issued == NTX) && (exp_q.size() == 0);
    end
    if (!drained) flag_fail("drain_timeout");
    repeat (4 * TIMEOUT) @(posedge hclk);
    chk("leftover_expected", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
